pm_cmd_sequencer: RTL and testbench

- Transmit-side counterpart to the pm-series combinational status decoder.
- Accepts command requests on a valid/ready interface and drives the decoder's 16-bit command word.
- Holds that word stable for a programmable settle window, captures the decoder's 13-bit status, and returns it with a wrapping sequence tag on a second valid/ready interface.
- Sits between the control bus and the decoder; the decoder itself is unchanged.

---
 rtl/pm_cmd_sequencer_if.sv | 28 ++
 rtl/pm_cmd_sequencer.sv | 78 +++++++
 tb/tb_pm_cmd_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/pm_cmd_sequencer_if.sv
// pm_cmd_sequencer_if: command request/response handshakes plus the decoder-side command/status bundle
//   master: control bus and decoder side (drives requests, rsp_ready and the decoder status)
//   slave : the sequencer (drives req_ready, command word to the decoder and the response)
interface pm_cmd_sequencer_if #(
    parameter int CMD_W  = 16,
    parameter int STAT_W = 13,
    parameter int TAG_W  = 4
);
    logic              req_valid;
    logic              req_ready;
    logic [CMD_W-1:0]  req_cmd;
    logic [CMD_W-1:0]  cmd_out;
    logic              cmd_active;
    logic [STAT_W-1:0] stat_in;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [STAT_W-1:0] rsp_stat;
    logic [TAG_W-1:0]  rsp_tag;
    logic              busy;
    modport master (
        output req_valid, req_cmd, rsp_ready, stat_in,
        input  req_ready, cmd_out, cmd_active, rsp_valid, rsp_stat, rsp_tag, busy
    );
    modport slave (
        input  req_valid, req_cmd, rsp_ready, stat_in,
        output req_ready, cmd_out, cmd_active, rsp_valid, rsp_stat, rsp_tag, busy
    );
endinterface

// File: rtl/pm_cmd_sequencer.sv
// pm_cmd_sequencer: applies a command word to the pm status decoder, waits SETTLE cycles, returns tagged status
//   clock_i : rising-edge clock
//   reset_i : synchronous active-high reset
//   bus     : slave side of pm_cmd_sequencer_if (request in, command/status to decoder, tagged response out)
module pm_cmd_sequencer #(
    parameter int CMD_W  = 16,
    parameter int STAT_W = 13,
    parameter int SETTLE = 2,
    parameter int TAG_W  = 4
) (
    input logic                clock_i,
    input logic                reset_i,
    pm_cmd_sequencer_if.slave  bus
);
    if (SETTLE < 1 || SETTLE > 15) begin : g_settle_check
        $error("pm_cmd_sequencer: SETTLE must be within 1..15");
    end
    typedef enum logic [1:0] {IDLE, HOLD, CAPTURE, RESP} state_t;
    localparam logic [3:0] CNT_INIT = 4'(SETTLE - 1);
    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [TAG_W-1:0]  tag_q, tag_d;
    logic [TAG_W-1:0]  rtag_q, rtag_d;
    logic [CMD_W-1:0]  cmd_q, cmd_d;
    logic [STAT_W-1:0] stat_q, stat_d;
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            tag_q   <= '0;
            rtag_q  <= '0;
            cmd_q   <= '0;
            stat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tag_q   <= tag_d;
            rtag_q  <= rtag_d;
            cmd_q   <= cmd_d;
            stat_q  <= stat_d;
        end
    end
    // The decoder is combinational, so stat_in is only trusted once cmd_out has been held
    // for the full settle window; it is sampled exactly once, in CAPTURE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tag_d   = tag_q;
        rtag_d  = rtag_q;
        cmd_d   = cmd_q;
        stat_d  = stat_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                cmd_d   = bus.req_cmd;
                cnt_d   = CNT_INIT;
                state_d = HOLD;
            end
            HOLD: if (cnt_q == 4'd0) state_d = CAPTURE;
                  else cnt_d = cnt_q - 4'd1;
            CAPTURE: begin
                stat_d  = bus.stat_in;
                rtag_d  = tag_q;
                tag_d   = tag_q + TAG_W'(1);
                state_d = RESP;
            end
            RESP: if (bus.rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
    // cmd_active spans accept edge to response handshake, which is exactly the non-IDLE time.
    assign bus.req_ready  = state_q == IDLE;
    assign bus.busy       = state_q != IDLE;
    assign bus.cmd_active = state_q != IDLE;
    assign bus.rsp_valid  = state_q == RESP;
    assign bus.cmd_out    = cmd_q;
    assign bus.rsp_stat   = stat_q;
    assign bus.rsp_tag    = rtag_q;
endmodule

// File: tb/tb_pm_cmd_sequencer.sv
// tb_pm_cmd_sequencer: checks pm_cmd_sequencer builds with SETTLE=2, 1 and 15 against a cycle-offset transaction model
module tb_pm_cmd_sequencer;
    logic clk = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    function automatic logic [12:0] decode(logic [15:0] c);
        return c[12:0] ^ c[15:3];
    endfunction

    task automatic chk(int s, string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL settle=%0d %s actual=%0h required=%0h", s, name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int S = g == 0 ? 2 : g == 1 ? 1 : 15;
        logic        rst = 1'b1;
        logic        gen = 1'b0;
        logic        done = 1'b0;
        logic [12:0] glitch = '0;
        pm_cmd_sequencer_if #(.CMD_W(16), .STAT_W(13), .TAG_W(4)) bus ();
        pm_cmd_sequencer #(.CMD_W(16), .STAT_W(13), .SETTLE(S), .TAG_W(4)) dut (
            .clock_i (clk),
            .reset_i (rst),
            .bus     (bus.slave)
        );
        // Decoder stand-in; glitch perturbs stat_in so only the CAPTURE-cycle value may reach rsp_stat.
        assign bus.stat_in = decode(bus.cmd_out) ^ glitch;
        always begin
            @(posedge clk);
            #1;
            glitch = gen ? 13'($urandom) : 13'd0;
        end

        // Transaction model: accept at cycle a, HOLD at a+1..a+S, capture at a+S+1, response from a+S+2.
        int          cyc = 0;
        int          m_acc = 0;
        int          m_cnt = 0;
        logic        m_busy = 1'b0;
        logic        m_valid = 1'b0;
        logic [15:0] m_cmd = '0;
        logic [12:0] m_new = '0;
        logic [12:0] m_stat = '0;
        logic [3:0]  m_tag = '0;
        always @(negedge clk) begin
            int k;
            logic ev;
            logic [12:0] es;
            logic [3:0] et;
            cyc++;
            k  = cyc - m_acc;
            ev = m_busy && k >= S + 2;
            es = ev ? m_new : m_stat;
            et = ev ? 4'(m_cnt) : m_tag;
            if (m_valid) begin
                chk(S, "req_ready", 32'(bus.req_ready), 32'(!m_busy));
                chk(S, "busy", 32'(bus.busy), 32'(m_busy));
                chk(S, "cmd_active", 32'(bus.cmd_active), 32'(m_busy));
                chk(S, "rsp_valid", 32'(bus.rsp_valid), 32'(ev));
                chk(S, "cmd_out", 32'(bus.cmd_out), 32'(m_cmd));
                chk(S, "rsp_stat", 32'(bus.rsp_stat), 32'(es));
                chk(S, "rsp_tag", 32'(bus.rsp_tag), 32'(et));
            end
            if (m_busy && k == S + 1) m_new = decode(m_cmd) ^ glitch;
            if (rst) begin
                m_busy = 1'b0; m_cmd = '0; m_stat = '0; m_tag = '0; m_cnt = 0; m_valid = 1'b1;
            end else if (ev && bus.rsp_ready) begin
                m_busy = 1'b0; m_stat = m_new; m_tag = 4'(m_cnt); m_cnt = (m_cnt + 1) % 16;
            end else if (!m_busy && bus.req_valid) begin
                m_busy = 1'b1; m_acc = cyc; m_cmd = bus.req_cmd;
            end
        end

        initial begin
            int n;
            int c;
            int cnt;
            logic [3:0] tags [17];
            int when [17];
            bus.req_valid = 1'b0;
            bus.req_cmd   = '0;
            bus.rsp_ready = 1'b1;
            repeat (2) step();
            rst = 1'b0;
            @(negedge clk);
            chk(S, "reset_req_ready", 32'(bus.req_ready), 32'd1);
            chk(S, "reset_outputs", 32'({bus.cmd_out, bus.cmd_active, bus.rsp_valid, bus.busy}), 32'd0);
            chk(S, "reset_rsp", 32'({bus.rsp_stat, bus.rsp_tag}), 32'd0);
            // single transaction, clean decoder
            step();
            bus.req_valid = 1'b1;
            bus.req_cmd   = 16'hA5C3;
            @(negedge clk);
            n = 0;
            do begin
                step();
                bus.req_valid = 1'b0;
                bus.req_cmd   = ~bus.req_cmd;
                @(negedge clk);
                n++;
            end while (!bus.rsp_valid && n < 40);
            chk(S, "latency", 32'(n), 32'(S + 2));
            chk(S, "a5c3_stat", 32'(bus.rsp_stat), 32'h117B);
            chk(S, "a5c3_tag", 32'(bus.rsp_tag), 32'd0);
            chk(S, "a5c3_cmd", 32'(bus.cmd_out), 32'hA5C3);
            // stalled response with glitching decoder and changing req_cmd
            step();
            bus.req_valid = 1'b1;
            bus.req_cmd   = 16'h1234;
            bus.rsp_ready = 1'b0;
            gen = 1'b1;
            @(negedge clk);
            n = 0;
            do begin
                step();
                bus.req_valid = 1'b0;
                bus.req_cmd   = 16'($urandom);
                @(negedge clk);
                n++;
            end while (!bus.rsp_valid && n < 40);
            chk(S, "stall_latency", 32'(n), 32'(S + 2));
            repeat (10) begin
                step();
                bus.req_valid = 1'b1;
                bus.req_cmd   = 16'($urandom);
                @(negedge clk);
                chk(S, "stall_valid", 32'(bus.rsp_valid), 32'd1);
                chk(S, "stall_ready", 32'(bus.req_ready), 32'd0);
                chk(S, "stall_tag", 32'(bus.rsp_tag), 32'd1);
                chk(S, "stall_cmd", 32'(bus.cmd_out), 32'h1234);
            end
            step();
            bus.req_valid = 1'b0;
            bus.rsp_ready = 1'b1;
            @(negedge clk);
            step();
            @(negedge clk);
            chk(S, "release_idle", 32'({bus.req_ready, bus.busy, bus.rsp_valid}), 32'b100);
            // reset during HOLD
            step();
            bus.req_valid = 1'b1;
            bus.req_cmd   = 16'h0F0F;
            @(negedge clk);
            step();
            bus.req_valid = 1'b0;
            rst = 1'b1;
            @(negedge clk);
            step();
            rst = 1'b0;
            @(negedge clk);
            chk(S, "abort_state", 32'({bus.req_ready, bus.busy, bus.rsp_valid}), 32'b100);
            chk(S, "abort_tag", 32'(bus.rsp_tag), 32'd0);
            // 17 back-to-back transactions
            step();
            bus.req_valid = 1'b1;
            bus.req_cmd   = 16'($urandom);
            c = 0;
            cnt = 0;
            while (cnt < 17 && c < 2000) begin
                @(negedge clk);
                if (bus.rsp_valid) begin
                    tags[cnt] = bus.rsp_tag;
                    when[cnt] = c;
                    cnt++;
                end
                step();
                bus.req_cmd = 16'($urandom);
                c++;
            end
            bus.req_valid = 1'b0;
            chk(S, "b2b_count", 32'(cnt), 32'd17);
            for (int i = 0; i < cnt; i++) chk(S, "b2b_tag", 32'(tags[i]), 32'(i % 16));
            for (int i = 1; i < cnt; i++) chk(S, "b2b_period", 32'(when[i] - when[i-1]), 32'(S + 3));
            // random traffic with occasional resets
            repeat (400) begin
                step();
                bus.req_valid = 1'($urandom);
                bus.rsp_ready = $urandom_range(0, 3) != 0;
                bus.req_cmd   = 16'($urandom);
                rst = $urandom_range(0, 99) == 0;
                @(negedge clk);
            end
            step();
            rst = 1'b0;
            bus.req_valid = 1'b0;
            done = 1'b1;
        end
    end

    initial begin
        int n;
        n = 0;
        while (!(g_inst[0].done && g_inst[1].done && g_inst[2].done) && n < 60000) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= 60000) begin
            failures++;
            $display("FAIL timeout actual=%0d required<60000 cycles", n);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
